// File: rtl/half_nn_pkg.sv
// Shared types for the half-precision layer datapath: word width, word type
// and the feeder state encoding.
package half_nn_pkg;

  localparam int unsigned HALF_BITS = 16;

  typedef logic [HALF_BITS-1:0] half_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/half_vector_buffer.sv
// Input-vector store: one write port, MULTS registered read ports.
// Deliberately has no reset so its contents outlive a feeder reset.
module half_vector_buffer #(
  parameter int unsigned BITS   = 16,
  parameter int unsigned LENGTH = 10,
  parameter int unsigned MULTS  = 2,
  parameter int unsigned AW     = 4
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [BITS-1:0]       i_wr_data,
  input  logic [MULTS*AW-1:0]   i_rd_addr,
  output logic [MULTS*BITS-1:0] o_rd_data
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(LENGTH - 1);

  logic [BITS-1:0]       r_mem [LENGTH];
  logic [MULTS*BITS-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en && (i_wr_addr <= LAST_ADDR)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    for (int unsigned g = 0; g < MULTS; g++) begin
      r_rd_data[g*BITS +: BITS] <= r_mem[i_rd_addr[g*AW +: AW]];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/half_layer_feeder.sv
// Streams input-vector and weight beats to a dot-product stage, one neuron per
// burst, waiting for the downstream result before moving to the next neuron.
module half_layer_feeder
  import half_nn_pkg::*;
#(
  parameter int unsigned BITS    = HALF_BITS,
  parameter int unsigned LENGTH  = 10,
  parameter int unsigned MULTS   = 2,
  parameter int unsigned NEURONS = 4,
  localparam int unsigned AW  = (LENGTH > 1) ? $clog2(LENGTH) : 1,
  localparam int unsigned WAW = (NEURONS * LENGTH > 1) ? $clog2(NEURONS * LENGTH) : 1,
  localparam int unsigned NW  = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_valid,
  input  logic [AW-1:0]         load_addr,
  input  logic [BITS-1:0]       load_data,
  input  logic                  start,
  output logic                  w_rd_en,
  output logic [WAW-1:0]        w_addr,
  input  logic [BITS*MULTS-1:0] w_data,
  output logic                  out_valid,
  output logic [BITS*MULTS-1:0] vector_a,
  output logic [BITS*MULTS-1:0] vector_b,
  output logic [NW-1:0]         neuron_idx,
  input  logic                  result_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BEATS = LENGTH / MULTS;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BW-1:0]  LAST_BEAT   = BW'(BEATS - 1);
  localparam logic [NW-1:0]  LAST_NEURON = NW'(NEURONS - 1);
  localparam logic [AW-1:0]  ELEM_STEP   = AW'(MULTS);
  localparam logic [WAW-1:0] ADDR_STEP   = WAW'(MULTS);
  localparam logic [WAW-1:0] ADDR_LEN    = WAW'(LENGTH);

  feeder_state_t  r_state;
  logic [BW-1:0]  r_beat;
  logic [NW-1:0]  r_neuron;
  logic [AW-1:0]  r_elem;
  logic [WAW-1:0] r_base;
  logic [WAW-1:0] r_addr;
  logic           r_rd_en;
  logic           r_out_valid;
  logic [NW-1:0]  r_neuron_idx;
  logic           r_busy;
  logic           r_done;

  logic                  w_wr_en;
  logic [MULTS*AW-1:0]   w_rd_addr;
  logic [BITS*MULTS-1:0] w_rd_data;

  assign w_wr_en = load_valid && (r_state == IDLE);

  // Buffer read is issued alongside the weight read so both land on the same cycle.
  always_comb begin
    w_rd_addr = '0;
    for (int unsigned g = 0; g < MULTS; g++) begin
      w_rd_addr[g*AW +: AW] = r_elem + AW'(g);
    end
  end

  half_vector_buffer #(
    .BITS   (BITS),
    .LENGTH (LENGTH),
    .MULTS  (MULTS),
    .AW     (AW)
  ) u_buffer (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (load_addr),
    .i_wr_data (load_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_neuron     <= '0;
      r_elem       <= '0;
      r_base       <= '0;
      r_addr       <= '0;
      r_rd_en      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_neuron_idx <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_out_valid <= r_rd_en;
      r_done      <= 1'b0;
      if (r_rd_en) begin
        r_neuron_idx <= r_neuron;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= ISSUE;
            r_neuron <= '0;
            r_beat   <= '0;
            r_elem   <= '0;
            r_base   <= '0;
            r_addr   <= '0;
            r_rd_en  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ISSUE: begin
          if (r_beat == LAST_BEAT) begin
            r_state <= WAIT;
            r_rd_en <= 1'b0;
            r_beat  <= '0;
            r_elem  <= '0;
          end else begin
            r_beat <= r_beat + 1'b1;
            r_elem <= r_elem + ELEM_STEP;
            r_addr <= r_addr + ADDR_STEP;
          end
        end
        WAIT: begin
          if (result_valid) begin
            if (r_neuron == LAST_NEURON) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ISSUE;
              r_neuron <= r_neuron + 1'b1;
              r_beat   <= '0;
              r_elem   <= '0;
              r_base   <= r_base + ADDR_LEN;
              r_addr   <= r_base + ADDR_LEN;
              r_rd_en  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rd_en    = r_rd_en;
  assign w_addr     = r_addr;
  assign out_valid  = r_out_valid;
  assign vector_a   = r_out_valid ? w_rd_data : '0;
  assign vector_b   = r_out_valid ? w_data : '0;
  assign neuron_idx = r_neuron_idx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_half_layer_feeder.sv
// Bench for half_layer_feeder: directed passes against a beat-list model.
module tb_half_layer_feeder;
  import half_nn_pkg::*;

  localparam int unsigned BITS    = 16;
  localparam int unsigned LENGTH  = 10;
  localparam int unsigned MULTS   = 2;
  localparam int unsigned NEURONS = 4;
  localparam int unsigned BEATS   = LENGTH / MULTS;
  localparam int unsigned AW      = 4;
  localparam int unsigned WAW     = 6;
  localparam int unsigned NW      = 2;
  localparam int unsigned VW      = BITS * MULTS;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          load_valid = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [BITS-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          result_valid = 1'b0;
  logic          w_rd_en;
  logic [WAW-1:0] w_addr;
  logic [VW-1:0] w_data = '0;
  logic          out_valid;
  logic [VW-1:0] vector_a;
  logic [VW-1:0] vector_b;
  logic [NW-1:0] neuron_idx;
  logic          busy;
  logic          done;

  half_layer_feeder #(
    .BITS    (BITS),
    .LENGTH  (LENGTH),
    .MULTS   (MULTS),
    .NEURONS (NEURONS)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .load_valid   (load_valid),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .w_rd_en      (w_rd_en),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .out_valid    (out_valid),
    .vector_a     (vector_a),
    .vector_b     (vector_b),
    .neuron_idx   (neuron_idx),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [NW-1:0] n;
  } beat_t;

  // x[i] = i+1 in half precision
  half_t xs [LENGTH] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                         16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900};
  half_t shadow [LENGTH];
  half_t mem [NEURONS*LENGTH];

  int unsigned exp_addr[$];
  beat_t       exp_beats[$];
  beat_t       cur;
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int unsigned last_n = 0;
  bit          mon_en = 1'b0;
  logic           rd_pend;
  logic [WAW-1:0] rd_a;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] got);
    checks++;
    failures++;
    $display("FAIL %s got=%0h exp=none", name, got);
  endtask

  // Synchronous weight memory: data one cycle after the read strobe, junk otherwise.
  always @(posedge clk) begin
    rd_pend = w_rd_en;
    rd_a    = w_addr;
    #1;
    for (int g = 0; g < MULTS; g++)
      w_data[g*BITS +: BITS] = rd_pend ? mem[int'(rd_a) + g] : BITS'($urandom);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (w_rd_en) begin
        if (exp_addr.size() == 0) fail("rd_unexpected", w_addr);
        else chk("w_addr", w_addr, exp_addr.pop_front());
      end
      if (out_valid) begin
        if (exp_beats.size() == 0) fail("beat_unexpected", vector_a);
        else begin
          cur = exp_beats.pop_front();
          chk("vector_a", vector_a, cur.a);
          chk("vector_b", vector_b, cur.b);
          chk("neuron_idx", neuron_idx, cur.n);
          last_n = cur.n;
        end
      end else begin
        chk("vec_a_idle", vector_a, 0);
        chk("vec_b_idle", vector_b, 0);
        if (busy) chk("neuron_hold", neuron_idx, last_n);
      end
      if (done) begin
        done_cnt++;
        chk("busy_with_done", busy, 1);
      end
    end
  end

  task automatic build_expect();
    beat_t e;
    for (int n = 0; n < NEURONS; n++)
      for (int k = 0; k < BEATS; k++) begin
        int unsigned base;
        base = n * LENGTH + k * MULTS;
        exp_addr.push_back(base);
        for (int g = 0; g < MULTS; g++) begin
          e.a[g*BITS +: BITS] = shadow[k*MULTS + g];
          e.b[g*BITS +: BITS] = mem[base + g];
        end
        e.n = NW'(n);
        exp_beats.push_back(e);
      end
  endtask

  task automatic run_pass(input int hold, input bit junk, input bit glitch, input bit rv_at_start,
                          input bit rst_mid, input bit lat, input logic [VW-1:0] a0,
                          input logic [VW-1:0] b0);
    int cyc, nbeat, rdc, cd, neur, dc0;
    bit handoff;
    cyc = 0; nbeat = 0; rdc = 0; cd = 0; neur = 0; handoff = 0;
    @(negedge clk);
    dc0 = done_cnt;
    build_expect();
    start = 1'b1;
    result_valid = rv_at_start;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc < hold);
      load_valid = 1'b0;
      result_valid = 1'b0;
      if (junk && cyc == 3) begin
        load_valid = 1'b1; load_addr = '0; load_data = 16'hFFFF;
      end
      if (lat && cyc == 1) begin
        chk("lat_rd_en", w_rd_en, 1);
        chk("lat_addr0", w_addr, 0);
        chk("lat_no_out", out_valid, 0);
      end
      if (lat && cyc == 2) begin
        chk("lat_out_valid", out_valid, 1);
        chk("first_a", vector_a, a0);
        chk("first_b", vector_b, b0);
      end
      if (handoff) begin
        handoff = 0;
        if (neur == NEURONS - 1) begin
          chk("done_pulse", done, 1);
          chk("busy_in_done", busy, 1);
          @(negedge clk);
          chk("done_fall", done, 0);
          chk("busy_fall", busy, 0);
          chk("done_once", done_cnt - dc0, 1);
          chk("queue_empty", exp_addr.size() + exp_beats.size(), 0);
          return;
        end
        chk("handoff_rd_en", w_rd_en, 1);
        chk("handoff_addr", w_addr, (neur + 1) * LENGTH);
        neur++; nbeat = 0; rdc = 0;
      end
      if (w_rd_en) begin
        rdc++;
        if (glitch && rdc == 2) result_valid = 1'b1;
      end
      if (rst_mid && neur == 1 && rdc == 2) begin
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_flags", {w_rd_en, out_valid, busy, done}, 0);
        chk("rst_addr", w_addr, 0);
        chk("rst_nidx", neuron_idx, 0);
        chk("rst_vecs", {vector_a, vector_b}, 0);
        exp_addr.delete();
        exp_beats.delete();
        last_n = 0;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_no_inflight", out_valid, 0);
        return;
      end
      if (out_valid) begin
        nbeat++;
        if (nbeat == BEATS) cd = 3;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          result_valid = 1'b1;
          handoff = 1;
        end
      end
    end
    fail("pass_timeout", cyc);
    exp_addr.delete();
    exp_beats.delete();
  endtask

  initial begin
    for (int i = 0; i < NEURONS*LENGTH; i++) mem[i] = 16'h3C00;
    for (int i = 0; i < LENGTH; i++) shadow[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_flags", {w_rd_en, out_valid, busy, done}, 0);
    chk("reset_addr", w_addr, 0);
    chk("reset_nidx", neuron_idx, 0);
    chk("reset_vecs", {vector_a, vector_b}, 0);
    rstn = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < LENGTH; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_addr = AW'(i);
      load_data = xs[i];
      shadow[i] = xs[i];
    end
    @(negedge clk);
    load_valid = 1'b0;

    // Unit weights, single start
    run_pass(1, 0, 0, 0, 0, 1, 32'h4000_3C00, 32'h3C00_3C00);

    // Distinct weights so lane order and neuron offsets show in vector_b
    for (int i = 0; i < NEURONS*LENGTH; i++) mem[i] = 16'h5000 + 16'(i) * 16'h0111;

    // Start held 4 cycles, stray load while busy
    run_pass(4, 1, 0, 0, 0, 0, '0, '0);
    repeat (5) @(negedge clk);
    chk("idle_after_hold", busy, 0);

    // Stray result_valid during issue and together with start
    run_pass(1, 0, 1, 1, 0, 0, '0, '0);

    // Reset at second beat of neuron 1, then replay
    run_pass(1, 0, 0, 0, 1, 0, '0, '0);
    repeat (2) @(negedge clk);
    chk("idle_after_reset", busy, 0);
    run_pass(1, 0, 0, 0, 0, 1, 32'h4000_3C00, 32'h5111_5000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
